// File: rtl/tetris_pkg.sv
// Shared Tetris datapath types and constants: FSM states, line-clear point table, level defaults.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PTS_W = 4;

  localparam logic [PTS_W-1:0] PTS_1 = 4'd1;
  localparam logic [PTS_W-1:0] PTS_2 = 4'd3;
  localparam logic [PTS_W-1:0] PTS_3 = 4'd5;
  localparam logic [PTS_W-1:0] PTS_4 = 4'd8;

  localparam int DEF_LINES_PER_LEVEL = 10;
  localparam int DEF_MAX_LEVEL       = 9;

  // Values outside 1..4 are malformed events and score nothing.
  function automatic logic [PTS_W-1:0] base_points(input logic [2:0] n);
    case (n)
      3'd1:    return PTS_1;
      3'd2:    return PTS_2;
      3'd3:    return PTS_3;
      3'd4:    return PTS_4;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/adder.sv
// Ripple-carry adder with carry-in and signed-overflow flag.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign overflow = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/score_keeper.sv
// Score/level tracker: scales line-clear points by (level+1) through repeated ripple adds.
// Build option SCORE_SATURATE_EN: clamp score at all ones instead of wrapping.
//
// state | meaning
// IDLE  | ready for a line-clear event
// ADD   | adding latched base points once per cycle, add_cnt times
// DONE  | done pulse; line counter and level update
module score_keeper
  import tetris_pkg::*;
#(
  parameter int WIDTH           = 12,
  parameter int LEVEL_W         = 4,
  parameter int LINES_PER_LEVEL = DEF_LINES_PER_LEVEL,
  parameter int MAX_LEVEL       = DEF_MAX_LEVEL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_valid,
  input  logic [2:0]         lines_cleared,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   score,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [LEVEL_W:0]   CNT_ONE = 1;
  localparam logic [LEVEL_W-1:0] LVL_ONE = 1;
  localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);
  localparam logic [4:0]         LPL     = 5'(LINES_PER_LEVEL);

  state_t             state, state_nxt;
  logic [PTS_W-1:0]   base_q, base_in;
  logic [2:0]         lines_q;
  logic [LEVEL_W:0]   add_cnt;
  logic [3:0]         line_cnt, line_nxt;
  logic [4:0]         line_sum;
  logic               lvl_step;
  logic               accept, last_add;
  logic [WIDTH:0]     add_a, add_b, add_sum;
  logic [WIDTH-1:0]   score_add;
  logic               unused_ovf;

  assign base_in  = base_points(lines_cleared);
  assign accept   = clear_valid && ready;
  assign last_add = (add_cnt == CNT_ONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (clear_valid) state_nxt = (base_in == '0) ? DONE : ADD;
      end
      ADD:  if (last_add) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // WIDTH+1 add so bit WIDTH carries the unsigned carry-out.
  assign add_a = {1'b0, score};
  assign add_b = (WIDTH+1)'(base_q);

  adder #(.WIDTH(WIDTH + 1)) u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (1'b0),
    .sum      (add_sum),
    .overflow (unused_ovf)
  );

`ifdef SCORE_SATURATE_EN
  assign score_add = add_sum[WIDTH] ? '1 : add_sum[WIDTH-1:0];
`else
  logic unused_cout;
  assign unused_cout = add_sum[WIDTH];
  assign score_add   = add_sum[WIDTH-1:0];
`endif

  assign line_sum = {1'b0, line_cnt} + {2'b00, lines_q};
  assign lvl_step = (line_sum >= LPL);
  assign line_nxt = lvl_step ? 4'(line_sum - LPL) : line_sum[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      score    <= '0;
      level    <= '0;
      line_cnt <= '0;
      base_q   <= '0;
      lines_q  <= '0;
      add_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          base_q  <= base_in;
          lines_q <= (base_in != '0) ? lines_cleared : 3'd0;
          add_cnt <= {1'b0, level} + CNT_ONE;
        end
        ADD: begin
          score   <= score_add;
          add_cnt <= add_cnt - CNT_ONE;
        end
        DONE: begin
          line_cnt <= line_nxt;
          if (lvl_step && (level != MAX_LVL)) level <= level + LVL_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
